// File: rtl/pipe_trace_buffer.sv
// Writeback-stage trace capture: circular record buffer with a post-trigger stop window.
// Optional TRACE_TIMESTAMP_EN prefixes each record with a 32-bit cycle stamp.
module pipe_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int DATA_W = 64,
  parameter int POST_TRIG = 4,
  localparam int AW = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 32,
`else
  localparam int TS_W = 0,
`endif
  localparam int REC_W = 14 + 2*DATA_W + TS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig_on_icode,
  input  logic [3:0]        trig_icode,
  input  logic [3:0]        W_icode,
  input  logic [1:0]        W_stat,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_idx,
  output logic              rd_valid,
  output logic [REC_W-1:0]  rd_rec,
  output logic [AW:0]       count,
  output logic [1:0]        state,
  output logic              triggered,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } st_t;

  st_t st_q, st_d;
  logic [AW-1:0] post_q, post_d;
  logic trig_q, trig_d;
  logic [AW-1:0] wptr_q;
  logic [AW:0] count_q;
  logic ovf_q;

  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] wr_rec;
  logic [14+2*DATA_W-1:0] base_rec;

  logic recordable;
  logic capturing;
  logic wr_en;
  logic hit;
  logic full;

  assign recordable = (W_icode != 4'h1);
  assign capturing = (st_q == ARMED) || (st_q == POST);
  assign wr_en = !arm && recordable && capturing;
  assign hit = (W_stat != 2'd0) ||
    (trig_on_icode && (W_icode == trig_icode));
  assign full = (count_q == (AW+1)'(DEPTH));

  assign base_rec = {W_stat, W_icode, W_dstE,
    W_dstM, W_valE, W_valM};

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else ts_q <= ts_q + 32'd1;
  end

  assign wr_rec = {ts_q, base_rec};
`else
  assign wr_rec = base_rec;
`endif

  always_comb begin
    st_d = st_q;
    post_d = post_q;
    trig_d = trig_q;
    unique case (st_q)
      IDLE: ;
      ARMED: begin
        if (wr_en && hit) begin
          trig_d = 1'b1;
          if (POST_TRIG == 0) begin
            st_d = DONE;
          end else begin
            st_d = POST;
            post_d = AW'(POST_TRIG);
          end
        end
      end
      POST: begin
        if (wr_en) begin
          post_d = post_q - AW'(1);
          if (post_q == AW'(1)) st_d = DONE;
        end
      end
      DONE: ;
    endcase
    if (arm) begin
      st_d = ARMED;
      trig_d = 1'b0;
      post_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      post_q <= '0;
      trig_q <= 1'b0;
    end else begin
      st_q <= st_d;
      post_q <= post_d;
      trig_q <= trig_d;
    end
  end

  // Pointer and count advance together; a full buffer overwrites its oldest slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else if (arm) begin
      wptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else if (wr_en) begin
      wptr_q <= wptr_q + AW'(1);
      if (full) ovf_q <= 1'b1;
      else count_q <= count_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= wr_rec;
  end

  logic [AW-1:0] rd_ent;
  logic rd_hit;

  assign rd_ent = wptr_q - count_q[AW-1:0] + rd_idx;
  assign rd_hit = ({1'b0, rd_idx} < count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_rec <= '0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      rd_rec <= rd_hit ? mem[rd_ent] : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  assign count = count_q;
  assign state = st_q;
  assign triggered = trig_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: directed scenarios plus random traffic
// compared against a queue-based trace model.
module tb_pipe_trace_buffer;

  localparam int DEPTH = 8;
  localparam int DATA_W = 64;
  localparam int POST_TRIG = 2;
  localparam int AW = 3;
  localparam int REC_W = 14 + 2*DATA_W;

  logic clk;
  logic rst;
  logic arm;
  logic trig_on_icode;
  logic [3:0] trig_icode;
  logic [3:0] W_icode;
  logic [1:0] W_stat;
  logic [3:0] W_dstE;
  logic [3:0] W_dstM;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;
  logic rd_en;
  logic [AW-1:0] rd_idx;
  logic rd_valid;
  logic [REC_W-1:0] rd_rec;
  logic [AW:0] count;
  logic [1:0] state;
  logic triggered;
  logic overflow;

  pipe_trace_buffer #(
    .DEPTH(DEPTH),
    .DATA_W(DATA_W),
    .POST_TRIG(POST_TRIG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .trig_on_icode(trig_on_icode),
    .trig_icode(trig_icode),
    .W_icode(W_icode),
    .W_stat(W_stat),
    .W_dstE(W_dstE),
    .W_dstM(W_dstM),
    .W_valE(W_valE),
    .W_valM(W_valM),
    .rd_en(rd_en),
    .rd_idx(rd_idx),
    .rd_valid(rd_valid),
    .rd_rec(rd_rec),
    .count(count),
    .state(state),
    .triggered(triggered),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  logic [REC_W-1:0] q[$];
  int m_state;
  int post_left;
  bit m_trig;
  bit m_ovf;
  bit m_rd_valid;
  logic [REC_W-1:0] m_rd_rec;

  task automatic chk(input string tag,
                     input logic [159:0] obs,
                     input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] pack();
    return {W_stat, W_icode, W_dstE, W_dstM,
            W_valE, W_valM};
  endfunction

  task automatic model_reset();
    q.delete();
    m_state = 0;
    post_left = 0;
    m_trig = 0;
    m_ovf = 0;
    m_rd_valid = 0;
    m_rd_rec = '0;
  endtask

  // Effect of one clock edge on the trace, from the current inputs.
  task automatic model_edge();
    bit rec;
    if (rd_en) begin
      m_rd_valid = 1;
      if (int'(rd_idx) < q.size()) m_rd_rec = q[rd_idx];
      else m_rd_rec = '0;
    end else begin
      m_rd_valid = 0;
    end
    rec = (W_icode != 4'h1);
    if (arm) begin
      q.delete();
      m_ovf = 0;
      m_trig = 0;
      m_state = 1;
    end else if (rec && (m_state == 1 || m_state == 2)) begin
      q.push_back(pack());
      if (q.size() > DEPTH) begin
        void'(q.pop_front());
        m_ovf = 1;
      end
      if (m_state == 1) begin
        if (W_stat != 0 ||
            (trig_on_icode && W_icode == trig_icode)) begin
          m_trig = 1;
          if (POST_TRIG == 0) m_state = 3;
          else begin
            m_state = 2;
            post_left = POST_TRIG;
          end
        end
      end else begin
        post_left--;
        if (post_left == 0) m_state = 3;
      end
    end
  endtask

  task automatic check_all();
    chk("state", 160'(state), 160'(m_state));
    chk("count", 160'(count), 160'(q.size()));
    chk("triggered", 160'(triggered), 160'(m_trig));
    chk("overflow", 160'(overflow), 160'(m_ovf));
    chk("rd_valid", 160'(rd_valid), 160'(m_rd_valid));
    chk("rd_rec", 160'(rd_rec), 160'(m_rd_rec));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    arm = 0;
    rd_en = 0;
    rd_idx = '0;
    W_icode = 4'h1;
    W_stat = 2'd0;
    W_dstE = 4'hf;
    W_dstM = 4'hf;
    W_valE = '0;
    W_valM = '0;
  endtask

  task automatic set_w(input logic [3:0] ic,
                       input logic [1:0] st,
                       input logic [63:0] ve);
    W_icode = ic;
    W_stat = st;
    W_dstE = 4'($urandom_range(0, 15));
    W_dstM = 4'($urandom_range(0, 15));
    W_valE = ve;
    W_valM = {$urandom, $urandom};
  endtask

  task automatic do_arm();
    idle_in();
    arm = 1;
    step();
    arm = 0;
  endtask

  task automatic rd(input int idx);
    idle_in();
    rd_en = 1;
    rd_idx = AW'(idx);
    step();
    rd_en = 0;
  endtask

  initial begin
    rst = 1;
    trig_on_icode = 0;
    trig_icode = 4'h0;
    idle_in();
    model_reset();
    #13;
    check_all();
    rst = 0;

    // 1: arm from IDLE
    arm = 1;
    step();
    chk("t1_state", 160'(state), 160'(1));
    arm = 0;

    // 2: nop skipped, oldest-first reads, out-of-range read
    do_arm();
    begin
      logic [3:0] ics [6] = '{4'h2, 4'h3, 4'h1, 4'h4, 4'h5, 4'h6};
      foreach (ics[i]) begin
        set_w(ics[i], 2'd0, 64'(i));
        step();
      end
    end
    chk("t2_count", 160'(count), 160'(5));
    rd(0);
    chk("t2_rd0_icode", 160'(rd_rec[139:136]), 160'(2));
    rd(4);
    chk("t2_rd4_icode", 160'(rd_rec[139:136]), 160'(6));
    rd(5);
    chk("t2_rd5_valid", 160'(rd_valid), 160'(1));
    chk("t2_rd5_rec", 160'(rd_rec), 160'(0));
    idle_in();
    step();

    // 3: wrap-around with overflow
    do_arm();
    for (int i = 1; i <= 11; i++) begin
      set_w(4'h3, 2'd0, 64'(i));
      step();
    end
    chk("t3_count", 160'(count), 160'(8));
    chk("t3_ovf", 160'(overflow), 160'(1));
    rd(0);
    chk("t3_rd0_valE", 160'(rd_rec[127:64]), 160'(4));
    rd(7);
    chk("t3_rd7_valE", 160'(rd_rec[127:64]), 160'(11));

    // 4: stat trigger and post window
    do_arm();
    for (int i = 1; i <= 7; i++) begin
      set_w(4'h2, (i == 4) ? 2'd2 : 2'd0, 64'(i));
      step();
      if (i == 4) chk("t4_post", 160'(state), 160'(2));
      if (i == 6) chk("t4_done", 160'(state), 160'(3));
    end
    chk("t4_count", 160'(count), 160'(6));
    chk("t4_trig", 160'(triggered), 160'(1));

    // 5: icode trigger on and off
    trig_icode = 4'h7;
    trig_on_icode = 1;
    do_arm();
    set_w(4'h2, 2'd0, 64'd1);
    step();
    set_w(4'h7, 2'd0, 64'd2);
    step();
    chk("t5_on", 160'(state), 160'(2));
    trig_on_icode = 0;
    do_arm();
    set_w(4'h2, 2'd0, 64'd1);
    step();
    set_w(4'h7, 2'd0, 64'd2);
    step();
    chk("t5_off", 160'(state), 160'(1));

    // 6: arm beats trigger; async reset from POST
    idle_in();
    set_w(4'h2, 2'd3, 64'd9);
    arm = 1;
    step();
    chk("t6_state", 160'(state), 160'(1));
    chk("t6_count", 160'(count), 160'(0));
    chk("t6_trig", 160'(triggered), 160'(0));
    arm = 0;
    set_w(4'h4, 2'd1, 64'd5);
    step();
    chk("t6_in_post", 160'(state), 160'(2));
    rd(0);
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 0;

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle_in();
      arm = ($urandom_range(0, 29) == 0) ||
            (m_state == 3 && $urandom_range(0, 3) == 0) ||
            (m_state == 0);
      trig_on_icode = 1'($urandom_range(0, 1));
      trig_icode = 4'($urandom_range(0, 15));
      set_w(4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0) ?
              2'($urandom_range(1, 3)) : 2'd0,
            {$urandom, $urandom});
      rd_en = 1'($urandom_range(0, 1));
      rd_idx = AW'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
